// File: rtl/lb_multi_dispatch.sv
// -----------------------------------------------------------------------------
// lb_multi_dispatch
//
// Tracks the free packet slots of every core and hands {core_id, slot}
// descriptors to PORT_COUNT independent consumer ports.
//
// Free slots arrive as control messages on the core return channel:
//   type 0 (release) pushes one slot into the FIFO of the source core,
//   type 3 (init)    replaces the FIFO content with slots 1..N.
// Each core owns a circular FIFO of depth SLOT_COUNT. Every cycle at most one
// descriptor is granted. The core is picked round-robin (sel_mode=0) or
// least-loaded, meaning the largest free count (sel_mode=1). The port is
// picked round-robin among ports whose output register can take a new entry.
//
// Optional feature: define LB_DISPATCH_STATS_EN to add the dispatch_counts
// output, which holds a 32-bit grant counter per core.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   ctrl_s_axis_*        control message input; tready is tied high,
//                        tuser carries the source core id
//   enabled_cores        per-core dispatch enable
//   slots_flush          per-core synchronous clear of slot state
//   sel_mode             0 round-robin, 1 least-loaded
//   slot_counts          free slot count per core, packed
//   slot_valids          per-core "count is non-zero"
//   slot_ins_errs        sticky per-core overflow / init clamp error
//   desc_valid/ready     per-port descriptor handshake
//   desc_data            per-port descriptor {core_id, zero pad, slot}
//   dispatch_counts      per-core grant counters (LB_DISPATCH_STATS_EN only)
// -----------------------------------------------------------------------------
module lb_multi_dispatch #(
  parameter int CORE_COUNT    = 8,
  parameter int SLOT_COUNT    = 32,
  parameter int PORT_COUNT    = 2,
  parameter int CTRL_WIDTH    = 36,
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int TAG_WIDTH     = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
  parameter int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CTRL_WIDTH-1:0]              ctrl_s_axis_tdata,
  input  logic                               ctrl_s_axis_tvalid,
  output logic                               ctrl_s_axis_tready,
  input  logic [CORE_ID_WIDTH-1:0]           ctrl_s_axis_tuser,
  input  logic [CORE_COUNT-1:0]              enabled_cores,
  input  logic [CORE_COUNT-1:0]              slots_flush,
  input  logic                               sel_mode,
  output logic [CORE_COUNT*SLOT_WIDTH-1:0]   slot_counts,
  output logic [CORE_COUNT-1:0]              slot_valids,
  output logic [CORE_COUNT-1:0]              slot_ins_errs,
  output logic [PORT_COUNT-1:0]              desc_valid,
  input  logic [PORT_COUNT-1:0]              desc_ready,
`ifdef LB_DISPATCH_STATS_EN
  output logic [PORT_COUNT*ID_TAG_WIDTH-1:0] desc_data,
  output logic [CORE_COUNT*32-1:0]           dispatch_counts
`else
  output logic [PORT_COUNT*ID_TAG_WIDTH-1:0] desc_data
`endif
);

  localparam int PTR_W     = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
  localparam int PORT_ID_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam logic [3:0]            TYPE_RELEASE = 4'd0;
  localparam logic [3:0]            TYPE_INIT    = 4'd3;
  localparam logic [SLOT_WIDTH-1:0] SLOT_MAX     = SLOT_WIDTH'(SLOT_COUNT);

  // Advance a FIFO pointer modulo SLOT_COUNT (depth need not be a power of 2)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOT_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Build {core_id, zero pad, slot}
  function automatic logic [ID_TAG_WIDTH-1:0] make_desc(input logic [CORE_ID_WIDTH-1:0] core,
                                                       input logic [SLOT_WIDTH-1:0] slot);
    logic [ID_TAG_WIDTH-1:0] d;
    d = '0;
    d[ID_TAG_WIDTH-1 -: CORE_ID_WIDTH] = core;
    d[SLOT_WIDTH-1:0] = slot;
    return d;
  endfunction

  // Registered control message
  logic                     ctrl_vld_q;
  logic [3:0]               ctrl_type_q;
  logic [CORE_ID_WIDTH-1:0] ctrl_core_q;
  logic [SLOT_WIDTH-1:0]    ctrl_data_q;

  // Per-core FIFO state
  logic [SLOT_WIDTH-1:0] mem_q   [CORE_COUNT][SLOT_COUNT];
  logic [SLOT_WIDTH-1:0] count_q [CORE_COUNT];
  logic [SLOT_WIDTH-1:0] count_d [CORE_COUNT];
  logic [PTR_W-1:0]      rd_q    [CORE_COUNT];
  logic [PTR_W-1:0]      rd_d    [CORE_COUNT];
  logic [PTR_W-1:0]      wr_q    [CORE_COUNT];
  logic [PTR_W-1:0]      wr_d    [CORE_COUNT];
  logic [CORE_COUNT-1:0] err_q;
  logic [CORE_COUNT-1:0] err_d;

  // Output registers and arbitration pointers
  logic [PORT_COUNT-1:0]   desc_vld_q;
  logic [PORT_COUNT-1:0]   desc_vld_d;
  logic [ID_TAG_WIDTH-1:0] desc_dat_q [PORT_COUNT];
  logic [ID_TAG_WIDTH-1:0] desc_dat_d [PORT_COUNT];
  logic [PORT_ID_W-1:0]    port_ptr_q, port_ptr_d;
  logic [CORE_ID_WIDTH-1:0] core_ptr_q, core_ptr_d;

  // Decode / arbitration signals
  logic [CORE_COUNT-1:0]    op_hit_s, rel_s, ini_s, pop_s, push_s, elig_s;
  logic [SLOT_WIDTH-1:0]    init_n_s;
  logic                     init_clamp_s;
  logic [PORT_COUNT-1:0]    port_free_s;
  logic                     port_found_s, core_found_s, grant_vld_s;
  logic                     take_s;
  logic [PORT_ID_W-1:0]     cand_port_s, grant_port_s;
  logic [CORE_ID_WIDTH-1:0] cand_core_s, grant_core_s;
  logic [SLOT_WIDTH-1:0]    head_slot_s;
  logic                     ctrl_unused_s;

  assign ctrl_s_axis_tready = 1'b1;
  assign ctrl_unused_s = ^{ctrl_s_axis_tdata[CTRL_WIDTH-5:16+SLOT_WIDTH],
                           ctrl_s_axis_tdata[15:0]};

  // Control message pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_vld_q  <= 1'b0;
      ctrl_type_q <= 4'd0;
      ctrl_core_q <= '0;
      ctrl_data_q <= '0;
    end else begin
      ctrl_vld_q  <= ctrl_s_axis_tvalid;
      ctrl_type_q <= ctrl_s_axis_tdata[CTRL_WIDTH-1 -: 4];
      ctrl_core_q <= ctrl_s_axis_tuser;
      ctrl_data_q <= ctrl_s_axis_tdata[16 +: SLOT_WIDTH];
    end
  end

  // Decode the registered message into per-core release/init strobes
  always_comb begin
    init_clamp_s = (ctrl_data_q > SLOT_MAX);
    init_n_s     = init_clamp_s ? SLOT_MAX : ctrl_data_q;
    op_hit_s     = '0;
    rel_s        = '0;
    ini_s        = '0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      // A flush on the target core swallows the pending operation
      op_hit_s[c] = ctrl_vld_q && (ctrl_core_q == CORE_ID_WIDTH'(c)) && !slots_flush[c];
      rel_s[c]    = op_hit_s[c] && (ctrl_type_q == TYPE_RELEASE);
      ini_s[c]    = op_hit_s[c] && (ctrl_type_q == TYPE_INIT);
    end
  end

  // Port and core selection; a grant needs both a free port and an eligible core
  always_comb begin
    elig_s       = '0;
    port_free_s  = '0;
    port_found_s = 1'b0;
    core_found_s = 1'b0;
    grant_port_s = '0;
    grant_core_s = '0;
    cand_port_s  = '0;
    cand_core_s  = '0;
    take_s       = 1'b0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      elig_s[c] = enabled_cores[c] && (count_q[c] != '0) && !slots_flush[c];
    end
    for (int p = 0; p < PORT_COUNT; p++) begin
      port_free_s[p] = !desc_vld_q[p] || desc_ready[p];
    end
    // port_ptr_q is the first port to try
    for (int k = 0; k < PORT_COUNT; k++) begin
      cand_port_s  = PORT_ID_W'((int'(port_ptr_q) + k) % PORT_COUNT);
      take_s       = !port_found_s && port_free_s[cand_port_s];
      port_found_s = port_found_s | take_s;
      grant_port_s = take_s ? cand_port_s : grant_port_s;
    end
    if (!sel_mode) begin
      // core_ptr_q holds the core after the last granted one
      for (int k = 0; k < CORE_COUNT; k++) begin
        cand_core_s  = CORE_ID_WIDTH'((int'(core_ptr_q) + k) % CORE_COUNT);
        take_s       = !core_found_s && elig_s[cand_core_s];
        core_found_s = core_found_s | take_s;
        grant_core_s = take_s ? cand_core_s : grant_core_s;
      end
    end else begin
      // Strictly-greater compare keeps the lowest index on ties
      for (int c = 0; c < CORE_COUNT; c++) begin
        take_s       = elig_s[c] && (!core_found_s || (count_q[c] > count_q[grant_core_s]));
        core_found_s = core_found_s | take_s;
        grant_core_s = take_s ? CORE_ID_WIDTH'(c) : grant_core_s;
      end
    end
    grant_vld_s = core_found_s && port_found_s;
  end

  assign head_slot_s = mem_q[grant_core_s][rd_q[grant_core_s]];

  // Per-core FIFO next state: flush beats init, init beats release/pop
  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      pop_s[c]  = grant_vld_s && (grant_core_s == CORE_ID_WIDTH'(c));
      // A pop in the same cycle frees the entry a full FIFO needs
      push_s[c] = rel_s[c] && ((count_q[c] < SLOT_MAX) || pop_s[c]);
      if (slots_flush[c]) begin
        count_d[c] = '0;
        rd_d[c]    = '0;
        wr_d[c]    = '0;
        err_d[c]   = 1'b0;
      end else if (ini_s[c]) begin
        count_d[c] = init_n_s;
        rd_d[c]    = '0;
        wr_d[c]    = (init_n_s == SLOT_MAX) ? '0 : PTR_W'(init_n_s);
        err_d[c]   = err_q[c] | init_clamp_s;
      end else begin
        count_d[c] = count_q[c] + SLOT_WIDTH'(push_s[c]) - SLOT_WIDTH'(pop_s[c]);
        rd_d[c]    = pop_s[c] ? ptr_inc(rd_q[c]) : rd_q[c];
        wr_d[c]    = push_s[c] ? ptr_inc(wr_q[c]) : wr_q[c];
        err_d[c]   = err_q[c] | (rel_s[c] && !push_s[c]);
      end
    end
  end

  // Per-core FIFO state and slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      for (int c = 0; c < CORE_COUNT; c++) begin
        count_q[c] <= '0;
        rd_q[c]    <= '0;
        wr_q[c]    <= '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
          mem_q[c][i] <= '0;
        end
      end
    end else begin
      err_q <= err_d;
      for (int c = 0; c < CORE_COUNT; c++) begin
        count_q[c] <= count_d[c];
        rd_q[c]    <= rd_d[c];
        wr_q[c]    <= wr_d[c];
        if (ini_s[c]) begin
          // Whole FIFO rewritten with slots 1..SLOT_COUNT; count limits what is used
          for (int i = 0; i < SLOT_COUNT; i++) begin
            mem_q[c][i] <= SLOT_WIDTH'(i + 1);
          end
        end else if (push_s[c]) begin
          mem_q[c][wr_q[c]] <= ctrl_data_q;
        end
      end
    end
  end

  // Output register next state and arbitration pointer update
  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      desc_vld_d[p] = desc_vld_q[p] && !desc_ready[p];
      desc_dat_d[p] = desc_dat_q[p];
    end
    if (grant_vld_s) begin
      desc_vld_d[grant_port_s] = 1'b1;
      desc_dat_d[grant_port_s] = make_desc(grant_core_s, head_slot_s);
      port_ptr_d = PORT_ID_W'((int'(grant_port_s) + 1) % PORT_COUNT);
      core_ptr_d = CORE_ID_WIDTH'((int'(grant_core_s) + 1) % CORE_COUNT);
    end else begin
      port_ptr_d = port_ptr_q;
      core_ptr_d = core_ptr_q;
    end
  end

  // Descriptor output registers and arbitration pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_vld_q <= '0;
      port_ptr_q <= '0;
      core_ptr_q <= '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        desc_dat_q[p] <= '0;
      end
    end else begin
      desc_vld_q <= desc_vld_d;
      port_ptr_q <= port_ptr_d;
      core_ptr_q <= core_ptr_d;
      for (int p = 0; p < PORT_COUNT; p++) begin
        desc_dat_q[p] <= desc_dat_d[p];
      end
    end
  end

  // Output packing
  always_comb begin
    slot_counts   = '0;
    slot_valids   = '0;
    desc_data     = '0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH] = count_q[c];
      slot_valids[c] = (count_q[c] != '0);
    end
    for (int p = 0; p < PORT_COUNT; p++) begin
      desc_data[p*ID_TAG_WIDTH +: ID_TAG_WIDTH] = desc_dat_q[p];
    end
  end

  assign slot_ins_errs = err_q;
  assign desc_valid    = desc_vld_q;

`ifdef LB_DISPATCH_STATS_EN
  logic [31:0] stat_q [CORE_COUNT];

  // Per-core grant counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        stat_q[c] <= 32'd0;
      end
    end else begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        if (slots_flush[c]) begin
          stat_q[c] <= 32'd0;
        end else if (pop_s[c]) begin
          stat_q[c] <= stat_q[c] + 32'd1;
        end
      end
    end
  end

  // Counter packing
  always_comb begin
    dispatch_counts = '0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      dispatch_counts[c*32 +: 32] = stat_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_lb_multi_dispatch.sv
// Self-checking bench for lb_multi_dispatch with a queue-based reference model.
module tb_lb_multi_dispatch;

  localparam int NC = 8;
  localparam int NS = 32;
  localparam int NP = 2;
  localparam int SW = 6;
  localparam int DW = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [35:0]       ctrl_s_axis_tdata = '0;
  logic              ctrl_s_axis_tvalid = 1'b0;
  logic              ctrl_s_axis_tready;
  logic [2:0]        ctrl_s_axis_tuser = '0;
  logic [NC-1:0]     enabled_cores = '0;
  logic [NC-1:0]     slots_flush = '0;
  logic              sel_mode = 1'b0;
  logic [NC*SW-1:0]  slot_counts;
  logic [NC-1:0]     slot_valids;
  logic [NC-1:0]     slot_ins_errs;
  logic [NP-1:0]     desc_valid;
  logic [NP-1:0]     desc_ready = '0;
  logic [NP*DW-1:0]  desc_data;
`ifdef LB_DISPATCH_STATS_EN
  logic [NC*32-1:0]  dispatch_counts;
`endif

  lb_multi_dispatch dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
    .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
    .ctrl_s_axis_tready (ctrl_s_axis_tready),
    .ctrl_s_axis_tuser  (ctrl_s_axis_tuser),
    .enabled_cores      (enabled_cores),
    .slots_flush        (slots_flush),
    .sel_mode           (sel_mode),
    .slot_counts        (slot_counts),
    .slot_valids        (slot_valids),
    .slot_ins_errs      (slot_ins_errs),
    .desc_valid         (desc_valid),
    .desc_ready         (desc_ready),
`ifdef LB_DISPATCH_STATS_EN
    .desc_data          (desc_data),
    .dispatch_counts    (dispatch_counts)
`else
    .desc_data          (desc_data)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [SW-1:0] mq [NC][$];
  bit            merr [NC];
  bit            mpv [NP];
  logic [DW-1:0] mpd [NP];
  int            mpptr, mcptr;
  bit            mcv;
  logic [3:0]    mct;
  logic [2:0]    mcc;
  logic [SW-1:0] mcd;

  // Log of descriptors loaded by the DUT, in grant order
  int lg_core[$];
  int lg_slot[$];
  int lg_port[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [35:0] mk_ctrl(input logic [3:0] t, input logic [SW-1:0] v);
    logic [63:0] r;
    logic [35:0] d;
    r = {$urandom(), $urandom()};
    d = r[35:0];
    d[35:32] = t;
    d[21:16] = v;
    return d;
  endfunction

  function automatic bit m_elig(input int c);
    return enabled_cores[c] && (mq[c].size() != 0) && !slots_flush[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      merr[c] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      mpv[p] = 1'b0;
      mpd[p] = '0;
    end
    mpptr = 0;
    mcptr = 0;
    mcv = 1'b0;
    mct = 4'd0;
    mcc = 3'd0;
    mcd = '0;
  endtask

  // One clock of the reference model, using the inputs currently driven
  task automatic model_step();
    int gp;
    int gc;
    int n;
    logic [SW-1:0] s;
    gp = -1;
    gc = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (mpptr + k) % NP;
      if (gp < 0 && (!mpv[p] || desc_ready[p])) gp = p;
    end
    if (!sel_mode) begin
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (mcptr + k) % NC;
        if (gc < 0 && m_elig(c)) gc = c;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (m_elig(c) && (gc < 0 || mq[c].size() > mq[gc].size())) gc = c;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (mpv[p] && desc_ready[p]) mpv[p] = 1'b0;
    end
    if (gp >= 0 && gc >= 0) begin
      s = mq[gc].pop_front();
      mpv[gp] = 1'b1;
      mpd[gp] = {gc[2:0], s};
      mpptr = (gp + 1) % NP;
      mcptr = (gc + 1) % NC;
    end
    if (mcv && !slots_flush[mcc]) begin
      if (mct == 4'd0) begin
        if (mq[mcc].size() < NS) mq[mcc].push_back(mcd);
        else merr[mcc] = 1'b1;
      end else if (mct == 4'd3) begin
        n = int'(mcd);
        if (n > NS) begin
          n = NS;
          merr[mcc] = 1'b1;
        end
        mq[mcc].delete();
        for (int i = 1; i <= n; i++) mq[mcc].push_back(SW'(i));
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (slots_flush[c]) begin
        mq[c].delete();
        merr[c] = 1'b0;
      end
    end
    mcv = ctrl_s_axis_tvalid;
    mct = ctrl_s_axis_tdata[35:32];
    mcc = ctrl_s_axis_tuser;
    mcd = ctrl_s_axis_tdata[21:16];
  endtask

  task automatic compare_all();
    check_val("tready", 64'(ctrl_s_axis_tready), 64'd1);
    for (int c = 0; c < NC; c++) begin
      check_val($sformatf("count[%0d]", c), 64'(slot_counts[c*SW +: SW]), 64'(mq[c].size()));
      check_val($sformatf("valid[%0d]", c), 64'(slot_valids[c]), 64'(mq[c].size() != 0));
      check_val($sformatf("err[%0d]", c), 64'(slot_ins_errs[c]), 64'(merr[c]));
    end
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("desc_valid[%0d]", p), 64'(desc_valid[p]), 64'(mpv[p]));
      check_val($sformatf("desc_data[%0d]", p), 64'(desc_data[p*DW +: DW]), 64'(mpd[p]));
    end
  endtask

  // Apply current inputs for one cycle, log new DUT descriptors, compare at negedge
  task automatic step();
    bit fr [NP];
    for (int p = 0; p < NP; p++) fr[p] = !desc_valid[p] || desc_ready[p];
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (fr[p] && desc_valid[p]) begin
        lg_core.push_back(int'(desc_data[p*DW+SW +: 3]));
        lg_slot.push_back(int'(desc_data[p*DW +: SW]));
        lg_port.push_back(p);
      end
    end
    compare_all();
  endtask

  task automatic send(input logic [3:0] t, input logic [2:0] core, input logic [SW-1:0] v);
    ctrl_s_axis_tdata  = mk_ctrl(t, v);
    ctrl_s_axis_tuser  = core;
    ctrl_s_axis_tvalid = 1'b1;
    step();
    ctrl_s_axis_tvalid = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_counts", 64'(slot_counts), 64'd0);
    check_val("rst_valids", 64'(slot_valids), 64'd0);
    check_val("rst_errs", 64'(slot_ins_errs), 64'd0);
    check_val("rst_desc_valid", 64'(desc_valid), 64'd0);
    check_val("rst_desc_data", 64'(desc_data), 64'd0);
    ctrl_s_axis_tvalid = 1'b0;
    enabled_cores = '0;
    slots_flush = '0;
    desc_ready = '0;
    sel_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    lg_core.delete();
    lg_slot.delete();
    lg_port.delete();
    compare_all();
  endtask

  initial begin
    int hits;
    int r;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Single enabled core, both ports ready: slots 1..4 alternate over ports
    enabled_cores = 8'b0000_0100;
    desc_ready = 2'b11;
    send(4'd3, 3'd2, 6'd4);
    repeat (10) step();
    check_val("s1_ngrants", 64'(lg_slot.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("s1_slot%0d", i), 64'(at(lg_slot, i)), 64'(i + 1));
      check_val($sformatf("s1_port%0d", i), 64'(at(lg_port, i)), 64'(i % 2));
      check_val($sformatf("s1_core%0d", i), 64'(at(lg_core, i)), 64'd2);
    end
    check_val("s1_count2", 64'(slot_counts[2*SW +: SW]), 64'd0);

    // Round-robin over cores 0..2, port 0 ready only
    do_reset();
    desc_ready = 2'b01;
    send(4'd3, 3'd0, 6'd2);
    send(4'd3, 3'd1, 6'd2);
    send(4'd3, 3'd2, 6'd2);
    enabled_cores = 8'b0000_0111;
    repeat (20) step();
    check_val("s2_ngrants", 64'(lg_core.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("s2_core%0d", i), 64'(at(lg_core, i)), 64'(i % 3));
    check_val("s2_port0_idle", 64'(desc_valid[0]), 64'd0);

    // Least-loaded with counts 5,2,7
    do_reset();
    desc_ready = 2'b11;
    sel_mode = 1'b1;
    send(4'd3, 3'd0, 6'd5);
    send(4'd3, 3'd1, 6'd2);
    send(4'd3, 3'd2, 6'd7);
    step();
    enabled_cores = 8'b0000_0111;
    repeat (25) step();
    check_val("s3_g0", 64'(at(lg_core, 0)), 64'd2);
    check_val("s3_g1", 64'(at(lg_core, 1)), 64'd2);
    check_val("s3_g2", 64'(at(lg_core, 2)), 64'd0);
    check_val("s3_ngrants", 64'(lg_core.size()), 64'd14);

    // Overflow and init clamp on core 1
    do_reset();
    send(4'd3, 3'd1, 6'd32);
    step();
    check_val("s4_full_count", 64'(slot_counts[1*SW +: SW]), 64'd32);
    check_val("s4_full_err", 64'(slot_ins_errs[1]), 64'd0);
    send(4'd0, 3'd1, 6'd5);
    step();
    check_val("s4_ovf_err", 64'(slot_ins_errs[1]), 64'd1);
    check_val("s4_ovf_count", 64'(slot_counts[1*SW +: SW]), 64'd32);
    send(4'd3, 3'd1, 6'd40);
    step();
    check_val("s4_clamp_count", 64'(slot_counts[1*SW +: SW]), 64'd32);
    check_val("s4_clamp_err", 64'(slot_ins_errs[1]), 64'd1);
    slots_flush = 8'b0000_0010;
    step();
    slots_flush = '0;
    check_val("s4_flush_err", 64'(slot_ins_errs[1]), 64'd0);
    check_val("s4_flush_count", 64'(slot_counts[1*SW +: SW]), 64'd0);

    // Release and pop on core 0 in the same cycle
    do_reset();
    desc_ready = 2'b11;
    send(4'd3, 3'd0, 6'd3);
    step();
    enabled_cores = 8'b0000_0001;
    send(4'd0, 3'd0, 6'd9);
    step();
    check_val("s5_count", 64'(slot_counts[0 +: SW]), 64'd2);
    repeat (10) step();
    check_val("s5_ngrants", 64'(lg_slot.size()), 64'd4);
    check_val("s5_slot0", 64'(at(lg_slot, 0)), 64'd1);
    check_val("s5_slot1", 64'(at(lg_slot, 1)), 64'd2);
    check_val("s5_slot2", 64'(at(lg_slot, 2)), 64'd3);
    check_val("s5_slot3", 64'(at(lg_slot, 3)), 64'd9);

    // Back-pressure: ports hold their descriptors
    do_reset();
    send(4'd3, 3'd4, 6'd5);
    enabled_cores = 8'b0001_0000;
    repeat (12) step();
    check_val("s6_hold_valid", 64'(desc_valid), 64'd3);
    check_val("s6_hold_d0", 64'(desc_data[0 +: DW]), 64'({3'd4, 6'd1}));
    check_val("s6_hold_d1", 64'(desc_data[DW +: DW]), 64'({3'd4, 6'd2}));
    check_val("s6_count4", 64'(slot_counts[4*SW +: SW]), 64'd3);

    // Flush core 3 while it is being dispatched
    enabled_cores = 8'b0001_1000;
    send(4'd3, 3'd3, 6'd6);
    desc_ready = 2'b11;
    repeat (2) step();
    slots_flush = 8'b0000_1000;
    step();
    slots_flush = '0;
    check_val("s6_flush_count3", 64'(slot_counts[3*SW +: SW]), 64'd0);
    lg_core.delete();
    repeat (15) step();
    hits = 0;
    foreach (lg_core[i]) if (lg_core[i] == 3) hits++;
    check_val("s6_no_core3", 64'(hits), 64'd0);

    // Randomised traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 9);
      ctrl_s_axis_tvalid = ($urandom_range(0, 1) == 1);
      ctrl_s_axis_tuser  = 3'($urandom_range(0, 7));
      if (r < 6)      ctrl_s_axis_tdata = mk_ctrl(4'd0, 6'($urandom_range(0, 63)));
      else if (r < 8) ctrl_s_axis_tdata = mk_ctrl(4'd3, 6'($urandom_range(0, 40)));
      else            ctrl_s_axis_tdata = mk_ctrl(4'($urandom_range(4, 15)), 6'($urandom_range(0, 63)));
      enabled_cores = 8'($urandom() | $urandom());
      for (int c = 0; c < NC; c++) slots_flush[c] = ($urandom_range(0, 63) == 0);
      desc_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) sel_mode = ~sel_mode;
      step();
    end
    ctrl_s_axis_tvalid = 1'b0;
    slots_flush = '0;
    do_reset();
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
